// File: rtl/random_ball_gen.sv
// ----------------------------------------------------------------------------
// random_ball_gen
//
// Sequential serve randomiser. On a request from the game-control FSM it draws
// a serve (location, velocity, angle) from a free-running Galois LFSR and holds
// the result until the consumer acknowledges it. Bounded rejection sampling
// keeps every field uniform inside its configured span; after MAX_TRIES
// consecutive rejections a fold-back value is used so a draw always finishes.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset, overrides everything
//   en            LFSR advance enable (the LFSR runs in every FSM state)
//   mode          0 = random, 1 = fixed centre serve, 2/3 = random (reserved)
//   seed_load     load seed_in into the LFSR this cycle (priority over en)
//   seed_in       reseed value; zero is replaced by SEED
//   req           serve request, honoured only in IDLE
//   ack           consumer accepts the held result, honoured only in DONE
//   busy          high while a random draw is in progress
//   valid         high while a result is held stable on the data outputs
//   ball_location {x, y}
//   ball_velocity unsigned speed
//   ball_angle    two's-complement angle in -ANG_MAX..+ANG_MAX
// ----------------------------------------------------------------------------
module random_ball_gen #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter int                X_W       = 11,
    parameter int                Y_W       = 11,
    parameter int                X_BASE    = 0,
    parameter int                X_SPAN    = 183,
    parameter int                Y_BASE    = 0,
    parameter int                Y_SPAN    = 183,
    parameter int                VEL_W     = 16,
    parameter int                VEL_MIN   = 64,
    parameter int                VEL_BITS  = 8,
    parameter int                ANG_W     = 16,
    parameter int                ANG_MAX   = 45,
    parameter int                MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 seed_load,
    input  logic [LFSR_W-1:0]    seed_in,
    input  logic                 req,
    input  logic                 ack,
    output logic                 busy,
    output logic                 valid,
    output logic [X_W+Y_W-1:0]   ball_location,
    output logic [VEL_W-1:0]     ball_velocity,
    output logic [ANG_W-1:0]     ball_angle
);

    // ------------------------------------------------------------------------
    // Derived sizes. Each sample width is the smallest power-of-two window
    // covering its span, so a rejected sample s always satisfies
    // SPAN <= s < 2*SPAN and s - SPAN lands back inside the span.
    // ------------------------------------------------------------------------
    localparam int A_RANGE = 2 * ANG_MAX + 1;
    localparam int XB      = (X_SPAN  > 1) ? $clog2(X_SPAN)  : 1;
    localparam int YB      = (Y_SPAN  > 1) ? $clog2(Y_SPAN)  : 1;
    localparam int AB      = (A_RANGE > 1) ? $clog2(A_RANGE) : 1;
    localparam int TW      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [XB:0]   X_SPAN_C  = (XB+1)'(X_SPAN);
    localparam logic [XB-1:0] X_SPAN_T  = XB'(X_SPAN);
    localparam logic [YB:0]   Y_SPAN_C  = (YB+1)'(Y_SPAN);
    localparam logic [YB-1:0] Y_SPAN_T  = YB'(Y_SPAN);
    localparam logic [AB:0]   A_RANGE_C = (AB+1)'(A_RANGE);
    localparam logic [AB-1:0] A_RANGE_T = AB'(A_RANGE);
    localparam logic [TW-1:0] TRY_LAST  = TW'(MAX_TRIES - 1);

    localparam logic [X_W-1:0]   X_BASE_T   = X_W'(X_BASE);
    localparam logic [Y_W-1:0]   Y_BASE_T   = Y_W'(Y_BASE);
    localparam logic [X_W-1:0]   X_CENTRE   = X_W'(X_BASE + X_SPAN / 2);
    localparam logic [Y_W-1:0]   Y_CENTRE   = Y_W'(Y_BASE + Y_SPAN / 2);
    localparam logic [VEL_W-1:0] VEL_MIN_T  = VEL_W'(VEL_MIN);
    localparam logic [ANG_W-1:0] ANG_MAX_T  = ANG_W'(ANG_MAX);

    // ------------------------------------------------------------------------
    // Parameter sanity. These fire at elaboration so a bad parameter set can
    // never silently produce out-of-range coordinates or a stuck LFSR.
    // ------------------------------------------------------------------------
    generate
        if (X_BASE + X_SPAN - 1 >= (1 << X_W)) begin : g_bad_x_range
            $error("random_ball_gen: X_BASE+X_SPAN-1 does not fit in X_W bits");
        end
        if (Y_BASE + Y_SPAN - 1 >= (1 << Y_W)) begin : g_bad_y_range
            $error("random_ball_gen: Y_BASE+Y_SPAN-1 does not fit in Y_W bits");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("random_ball_gen: SEED must be nonzero");
        end
        if (XB > LFSR_W || YB > LFSR_W || AB > LFSR_W || VEL_BITS > LFSR_W) begin : g_bad_sample
            $error("random_ball_gen: a sample field is wider than the LFSR");
        end
        if (MAX_TRIES < 1) begin : g_bad_tries
            $error("random_ball_gen: MAX_TRIES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        GEN_X,
        GEN_Y,
        GEN_V,
        GEN_A,
        DONE
    } state_t;

    state_t              state;
    logic [LFSR_W-1:0]   lfsr;
    logic [LFSR_W-1:0]   lfsr_next;
    logic [TW-1:0]       try_cnt;
    logic [X_W-1:0]      x_val;
    logic [Y_W-1:0]      y_val;
    logic [VEL_W-1:0]    v_val;

    logic [XB-1:0]       x_sample;
    logic [YB-1:0]       y_sample;
    logic [AB-1:0]       a_sample;
    logic                x_hit;
    logic                y_hit;
    logic                a_hit;
    logic                last_try;
    logic [X_W-1:0]      x_pick;
    logic [Y_W-1:0]      y_pick;
    logic [AB-1:0]       a_pick;
    logic [ANG_W-1:0]    a_angle;
    logic [VEL_W-1:0]    v_draw;

    // ------------------------------------------------------------------------
    // Right-shifting Galois step: the bit falling out of the bottom decides
    // whether the feedback mask is folded into the shifted register.
    // ------------------------------------------------------------------------
    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

    // ------------------------------------------------------------------------
    // LFSR register. Reseeding wins over advancing, and a zero seed is swapped
    // for SEED because an all-zero Galois register would never leave zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED : seed_in;
        end else if (en) begin
            lfsr <= lfsr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Per-field sampling. Each field takes the low bits of the current LFSR
    // word; a hit is accepted directly, otherwise the fold-back value s-SPAN
    // is prepared for the case where the try budget is exhausted.
    // ------------------------------------------------------------------------
    always_comb begin
        x_sample = lfsr[XB-1:0];
        y_sample = lfsr[YB-1:0];
        a_sample = lfsr[AB-1:0];

        x_hit    = {1'b0, x_sample} < X_SPAN_C;
        y_hit    = {1'b0, y_sample} < Y_SPAN_C;
        a_hit    = {1'b0, a_sample} < A_RANGE_C;
        last_try = (try_cnt == TRY_LAST);

        x_pick   = x_hit ? (X_BASE_T + X_W'(x_sample))
                         : (X_BASE_T + X_W'(x_sample - X_SPAN_T));
        y_pick   = y_hit ? (Y_BASE_T + Y_W'(y_sample))
                         : (Y_BASE_T + Y_W'(y_sample - Y_SPAN_T));
        a_pick   = a_hit ? a_sample : (a_sample - A_RANGE_T);

        // Zero-extend the 0..2*ANG_MAX index, then shift it to be centred on 0.
        a_angle  = ANG_W'(a_pick) - ANG_MAX_T;
        v_draw   = VEL_MIN_T + VEL_W'(lfsr[VEL_BITS-1:0]);
    end

    // ------------------------------------------------------------------------
    // Serve FSM with registered outputs. Partial results are staged in
    // x_val/y_val/v_val and only copied to the ports on entry to DONE, so the
    // consumer never sees a half-built serve. The held outputs stay on the
    // ports after ack until the next serve replaces them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            valid         <= 1'b0;
            try_cnt       <= '0;
            x_val         <= '0;
            y_val         <= '0;
            v_val         <= '0;
            ball_location <= '0;
            ball_velocity <= '0;
            ball_angle    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        try_cnt <= '0;
                        if (mode == 2'd1) begin
                            ball_location <= {X_CENTRE, Y_CENTRE};
                            ball_velocity <= VEL_MIN_T;
                            ball_angle    <= '0;
                            valid         <= 1'b1;
                            state         <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= GEN_X;
                        end
                    end
                end

                GEN_X: begin
                    if (x_hit || last_try) begin
                        x_val   <= x_pick;
                        try_cnt <= '0;
                        state   <= GEN_Y;
                    end else begin
                        try_cnt <= try_cnt + TW'(1);
                    end
                end

                GEN_Y: begin
                    if (y_hit || last_try) begin
                        y_val   <= y_pick;
                        try_cnt <= '0;
                        state   <= GEN_V;
                    end else begin
                        try_cnt <= try_cnt + TW'(1);
                    end
                end

                GEN_V: begin
                    v_val <= v_draw;
                    state <= GEN_A;
                end

                GEN_A: begin
                    if (a_hit || last_try) begin
                        ball_location <= {x_val, y_val};
                        ball_velocity <= v_val;
                        ball_angle    <= a_angle;
                        try_cnt       <= '0;
                        busy          <= 1'b0;
                        valid         <= 1'b1;
                        state         <= DONE;
                    end else begin
                        try_cnt <= try_cnt + TW'(1);
                    end
                end

                DONE: begin
                    // A req arriving with ack is dropped; the requester re-asserts.
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_ball_gen.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_random_ball_gen
//
// Directed bench for random_ball_gen. One instance uses the default parameter
// set; a second one (X_SPAN=129, MAX_TRIES=1) exercises the single-try
// fold-back. A small LFSR reference tracks the default instance's generator
// so random draws can be predicted bit-exactly.
// ----------------------------------------------------------------------------
module tb_random_ball_gen;

    localparam logic [15:0] SEED      = 16'hACE1;
    localparam logic [15:0] TAPS      = 16'hB400;
    localparam int          MAX_TRIES = 8;
    localparam int          WAIT_MAX  = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, seed_load, req, ack;
    logic [1:0]  mode;
    logic [15:0] seed_in;
    logic        busy, valid;
    logic [21:0] loc;
    logic [15:0] vel, ang;

    logic        en2, seed_load2, req2, ack2;
    logic [1:0]  mode2;
    logic [15:0] seed_in2;
    logic        busy2, valid2;
    logic [21:0] loc2;
    logic [15:0] vel2, ang2;

    logic [15:0] ref_lfsr;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [21:0] hold_loc;
    logic [15:0] hold_vel, hold_ang;

    always #5 clk = ~clk;

    random_ball_gen dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .seed_load(seed_load), .seed_in(seed_in), .req(req), .ack(ack),
        .busy(busy), .valid(valid), .ball_location(loc),
        .ball_velocity(vel), .ball_angle(ang)
    );

    random_ball_gen #(.X_SPAN(129), .MAX_TRIES(1)) dut_fb (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2),
        .seed_load(seed_load2), .seed_in(seed_in2), .req(req2), .ack(ack2),
        .busy(busy2), .valid(valid2), .ball_location(loc2),
        .ball_velocity(vel2), .ball_angle(ang2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    // Reference generator for the default instance
    always @(posedge clk) begin
        if (rst)
            ref_lfsr <= SEED;
        else if (seed_load)
            ref_lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
        else if (en)
            ref_lfsr <= lfsr_step(ref_lfsr);
    end

    // Predicts a default-parameter draw with en=1 from the LFSR word seen in
    // the first GEN_X cycle; n is the number of generation cycles.
    function automatic void model_draw(input logic [15:0] v0,
                                       output logic [10:0] mx, output logic [10:0] my,
                                       output logic [15:0] mv, output logic [15:0] ma,
                                       output int n);
        logic [15:0] v;
        int s;
        v = v0; n = 0; mx = '0; my = '0; ma = '0;
        for (int t = 0; t < MAX_TRIES; t++) begin
            s = int'(v[7:0]); n++; v = lfsr_step(v);
            if (s < 183) begin mx = 11'(s); break; end
            if (t == MAX_TRIES - 1) mx = 11'(s - 183);
        end
        for (int t = 0; t < MAX_TRIES; t++) begin
            s = int'(v[7:0]); n++; v = lfsr_step(v);
            if (s < 183) begin my = 11'(s); break; end
            if (t == MAX_TRIES - 1) my = 11'(s - 183);
        end
        mv = 16'(64 + int'(v[7:0])); n++; v = lfsr_step(v);
        for (int t = 0; t < MAX_TRIES; t++) begin
            s = int'(v[6:0]); n++; v = lfsr_step(v);
            if (s < 91) begin ma = 16'(s - 45); break; end
            if (t == MAX_TRIES - 1) ma = 16'(s - 91 - 45);
        end
    endfunction

    // Pulses req on the default instance and waits (bounded) for valid.
    // v0 is the reference LFSR word the first GEN_X cycle will sample.
    task automatic run_draw(output logic [15:0] v0, output int lat);
        @(negedge clk); req = 1'b1;
        @(posedge clk); #1;
        v0  = ref_lfsr;
        req = 1'b0;
        lat = 0;
        while (!valid && lat < WAIT_MAX) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pulse_ack;
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; mode = 2'd0; seed_load = 1'b0; seed_in = 16'h0;
        req = 1'b0; ack = 1'b0;
        en2 = 1'b0; mode2 = 2'd0; seed_load2 = 1'b0; seed_in2 = 16'h0;
        req2 = 1'b0; ack2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (loc !== 22'd0) begin n_fail++; $display("[TB] FAIL reset_location: got %h want 0", loc); end
        n_checks++;
        if (vel !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_velocity: got %0d want 0", vel); end
        n_checks++;
        if (ang !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_angle: got %h want 0", ang); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_centre;
        @(negedge clk); mode = 2'd1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        n_checks++;
        if ({valid, busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL centre_latency: valid/busy got %b want 10", {valid, busy}); end
        n_checks++;
        if (loc !== {11'd91, 11'd91}) begin n_fail++; $display("[TB] FAIL centre_location: got %h want %h", loc, {11'd91, 11'd91}); end
        n_checks++;
        if (vel !== 16'd64) begin n_fail++; $display("[TB] FAIL centre_velocity: got %0d want 64", vel); end
        n_checks++;
        if (ang !== 16'd0) begin n_fail++; $display("[TB] FAIL centre_angle: got %h want 0", ang); end
        pulse_ack();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL centre_ack: valid got %b want 0", valid); end
    endtask

    task automatic test_random_draw;
        logic [15:0] v0, ev, ea;
        logic [10:0] ex, ey;
        int lat, n;
        @(negedge clk); en = 1'b1; mode = 2'd0; seed_load = 1'b1; seed_in = 16'h01D5;
        @(negedge clk); seed_load = 1'b0;
        run_draw(v0, lat);
        model_draw(v0, ex, ey, ev, ea, n);
        n_checks++;
        if (lat !== n || lat < 4 || lat > 25) begin n_fail++; $display("[TB] FAIL random_latency: got %0d want %0d (4..25)", lat, n); end
        n_checks++;
        if (loc[21:11] > 11'd182 || loc[10:0] > 11'd182 || vel < 16'd64 || vel > 16'd319 ||
            $signed(ang) < -16'sd45 || $signed(ang) > 16'sd45) begin
            n_fail++; $display("[TB] FAIL random_range: got loc=%h vel=%0d ang=%0d", loc, vel, $signed(ang));
        end
        n_checks++;
        if (loc !== {ex, ey}) begin n_fail++; $display("[TB] FAIL random_location: got %h want %h", loc, {ex, ey}); end
        n_checks++;
        if (vel !== ev) begin n_fail++; $display("[TB] FAIL random_velocity: got %0d want %0d", vel, ev); end
        n_checks++;
        if (ang !== ea) begin n_fail++; $display("[TB] FAIL random_angle: got %0d want %0d", $signed(ang), $signed(ea)); end
        hold_loc = {ex, ey};
        hold_vel = ev;
        hold_ang = ea;
    endtask

    task automatic test_hold_ack;
        @(negedge clk); req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({valid, busy, loc, vel, ang} !== {1'b1, 1'b0, hold_loc, hold_vel, hold_ang}) begin
                n_fail++;
                $display("[TB] FAIL hold_cycle%0d: got v=%b b=%b loc=%h vel=%0d ang=%h want v=1 b=0 loc=%h vel=%0d ang=%h",
                         i, valid, busy, loc, vel, ang, hold_loc, hold_vel, hold_ang);
            end
        end
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; req = 1'b0;
        n_checks++;
        if ({valid, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL ack_release: valid/busy got %b want 00", {valid, busy}); end
        @(posedge clk); #1;
        n_checks++;
        if ({valid, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL req_with_ack_ignored: valid/busy got %b want 00", {valid, busy}); end
    endtask

    task automatic test_zero_seed;
        logic [15:0] v0, ev, ea;
        logic [10:0] ex, ey;
        int lat, n, bad;
        @(negedge clk); en = 1'b0; mode = 2'd0; seed_load = 1'b1; seed_in = 16'h0000;
        @(negedge clk); seed_load = 1'b0;
        // LFSR frozen at ACE1: low byte 225 and low 7 bits 97 are both rejected,
        // so every field folds back after the full try budget.
        run_draw(v0, lat);
        n_checks++;
        if (lat !== 25) begin n_fail++; $display("[TB] FAIL zero_seed_latency: got %0d want 25", lat); end
        n_checks++;
        if (loc !== {11'd42, 11'd42}) begin n_fail++; $display("[TB] FAIL zero_seed_location: got %h want %h", loc, {11'd42, 11'd42}); end
        n_checks++;
        if (vel !== 16'd289) begin n_fail++; $display("[TB] FAIL zero_seed_velocity: got %0d want 289", vel); end
        n_checks++;
        if (ang !== 16'hFFD9) begin n_fail++; $display("[TB] FAIL zero_seed_angle: got %0d want -39", $signed(ang)); end
        pulse_ack();

        @(negedge clk); en = 1'b1;
        bad = 0;
        for (int i = 0; i < 3000 && bad < 5; i++) begin
            mode = (i % 4 == 1) ? 2'd3 : ((i % 4 == 2) ? 2'd2 : 2'd0);
            run_draw(v0, lat);
            model_draw(v0, ex, ey, ev, ea, n);
            n_checks++;
            if ({lat, loc, vel, ang} !== {n, ex, ey, ev, ea}) begin
                n_fail++; bad++;
                $display("[TB] FAIL soak_draw%0d: got lat=%0d loc=%h vel=%0d ang=%h want lat=%0d loc=%h vel=%0d ang=%h",
                         i, lat, loc, vel, ang, n, {ex, ey}, ev, ea);
            end
            n_checks++;
            if (loc[21:11] > 11'd182 || loc[10:0] > 11'd182 || vel < 16'd64 || vel > 16'd319 ||
                $signed(ang) < -16'sd45 || $signed(ang) > 16'sd45) begin
                n_fail++; bad++;
                $display("[TB] FAIL soak_range%0d: got loc=%h vel=%0d ang=%0d", i, loc, vel, $signed(ang));
            end
            pulse_ack();
        end
        mode = 2'd0;
        $display("[TB] soak draws complete");
    endtask

    task automatic test_fallback;
        int lat;
        @(negedge clk); en2 = 1'b0; mode2 = 2'd0; seed_load2 = 1'b1; seed_in2 = 16'h00C8;
        @(negedge clk); seed_load2 = 1'b0; req2 = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0;
        lat = 0;
        while (!valid2 && lat < WAIT_MAX) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("[TB] FAIL fallback_latency: got %0d want 4", lat); end
        n_checks++;
        if (loc2 !== {11'd71, 11'd17}) begin n_fail++; $display("[TB] FAIL fallback_location: got %h want %h", loc2, {11'd71, 11'd17}); end
        n_checks++;
        if (vel2 !== 16'd264) begin n_fail++; $display("[TB] FAIL fallback_velocity: got %0d want 264", vel2); end
        n_checks++;
        if (ang2 !== 16'd27) begin n_fail++; $display("[TB] FAIL fallback_angle: got %0d want 27", $signed(ang2)); end
        @(negedge clk); ack2 = 1'b1;
        @(posedge clk); #1;
        ack2 = 1'b0;
        n_checks++;
        if (valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL fallback_ack: valid got %b want 0", valid2); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] v0;
        int lat;
        @(negedge clk); en = 1'b0; mode = 2'd0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        // Eight rejected GEN_X cycles, then two cycles into GEN_Y.
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL mid_gen_busy: busy/valid got %b want 10", {busy, valid}); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, valid, loc, vel, ang} !== 56'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_gen_reset: got b=%b v=%b loc=%h vel=%0d ang=%h want all 0", busy, valid, loc, vel, ang);
        end
        @(negedge clk); rst = 1'b0;
        run_draw(v0, lat);
        n_checks++;
        if ({lat, loc, vel, ang} !== {32'd25, 11'd42, 11'd42, 16'd289, 16'hFFD9}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_draw: got lat=%0d loc=%h vel=%0d ang=%0d want lat=25 loc=%h vel=289 ang=-39",
                     lat, loc, vel, $signed(ang), {11'd42, 11'd42});
        end
        pulse_ack();
    endtask

    initial begin
        $display("[TB] starting random_ball_gen bench");
        test_reset();
        test_centre();
        test_random_draw();
        test_hold_ack();
        test_zero_seed();
        test_fallback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
